// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the VeriRISC CPU and an external loader/debug port.
// Define ARB_STATS_EN to add the stat_stall_cnt stall-cycle counter output.
module mem_arbiter #(
    parameter int AWIDTH       = 5,
    parameter int DWIDTH       = 8,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [AWIDTH-1:0] ldr_addr,
    input  logic [DWIDTH-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_last,
    output logic              ldr_rvalid,
    output logic [DWIDTH-1:0] ldr_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_stall_cnt
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ARB_CPU,
        ARB_TURN,
        ARB_LDR
    } arb_state_t;

    arb_state_t    state;
    arb_state_t    next_state;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] beat_cnt;
    logic          cpu_busy;
    logic          starve_hit;
    logic          ldr_beat;

    assign cpu_busy   = cpu_rd | cpu_wr;
    assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_CPU;
        end else begin
            state <= next_state;
        end
    end

    // All strobes decode from the registered state; a simultaneous CPU read+write lets the write win.
    always_comb begin
        next_state = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        cpu_stall  = 1'b0;
        ldr_gnt    = 1'b0;
        ldr_last   = 1'b0;
        ldr_beat   = 1'b0;
        case (state)
            ARB_CPU: begin
                mem_wr = cpu_wr;
                mem_rd = cpu_rd & ~cpu_wr;
                if (ldr_req && (halt || !cpu_busy || starve_hit)) begin
                    next_state = ARB_TURN;
                end
            end
            ARB_TURN: begin
                cpu_stall  = cpu_busy;
                next_state = ARB_LDR;
            end
            ARB_LDR: begin
                ldr_gnt   = 1'b1;
                cpu_stall = cpu_busy;
                if (ldr_req) begin
                    ldr_beat  = 1'b1;
                    mem_rd    = ~ldr_we;
                    mem_wr    = ldr_we;
                    mem_addr  = ldr_addr;
                    mem_wdata = ldr_wdata;
                    ldr_last  = (beat_cnt == BW'(MAX_BURST - 1));
                    if (ldr_last) begin
                        next_state = ARB_CPU;
                    end
                end else begin
                    next_state = ARB_CPU;
                end
            end
            default: next_state = ARB_CPU;
        endcase
    end

    // Starvation only accrues while the CPU holds the bus; beats are counted per grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ARB_CPU: begin
                    if (!ldr_req) begin
                        starve_cnt <= '0;
                    end else if (cpu_busy && (starve_cnt != SW'(STARVE_LIMIT))) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                ARB_TURN: begin
                    beat_cnt   <= '0;
                    starve_cnt <= '0;
                end
                ARB_LDR: begin
                    starve_cnt <= '0;
                    if (ldr_beat) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: begin
                    starve_cnt <= '0;
                    beat_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ldr_rvalid <= 1'b0;
        end else begin
            ldr_rvalid <= ldr_beat & ~ldr_we;
        end
    end

    // Memory returns data one cycle after the strobe, which is exactly when ldr_rvalid is high.
    assign ldr_rdata = ldr_rvalid ? mem_rdata : '0;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cnt <= '0;
        end else if (cpu_stall && (stat_stall_cnt != 16'hFFFF)) begin
            stat_stall_cnt <= stat_stall_cnt + 16'd1;
        end
    end
`endif

    cpu_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(cpu_rd && cpu_wr));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a simple 1-cycle-latency memory model.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       halt = 1'b0;
    logic       cpu_rd = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [4:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_stall;
    logic       ldr_req = 1'b0;
    logic       ldr_we = 1'b0;
    logic [4:0] ldr_addr = '0;
    logic [7:0] ldr_wdata = '0;
    logic       ldr_gnt;
    logic       ldr_last;
    logic       ldr_rvalid;
    logic [7:0] ldr_rdata;
    logic       mem_rd;
    logic       mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [15:0] stat_stall_cnt;
`endif

    logic [7:0] tb_mem [32];
    int         check_cnt = 0;
    int         pass_cnt = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_gnt   (ldr_gnt),
        .ldr_last  (ldr_last),
        .ldr_rvalid(ldr_rvalid),
        .ldr_rdata (ldr_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: synchronous write, registered read data.
    always @(posedge clk) begin
        if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= tb_mem[mem_addr];
    end

    // Inputs change at the falling edge so outputs settle well before the next rising edge.
    task automatic applyStimulus(input logic r, input logic h, input logic cr, input logic cw,
                                 input logic [4:0] ca, input logic [7:0] cd, input logic lr,
                                 input logic lw, input logic [4:0] la, input logic [7:0] ld);
        @(negedge clk);
        rst       = r;
        halt      = h;
        cpu_rd    = cr;
        cpu_wr    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        ldr_req   = lr;
        ldr_we    = lw;
        ldr_addr  = la;
        ldr_wdata = ld;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) begin
            pass_cnt++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int         performed;
        logic [4:0] ca;

        // Reset held for two rising edges
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_stall", 32'(cpu_stall), 32'd0);
        checkOutput("rst_gnt", 32'(ldr_gnt), 32'd0);
        checkOutput("rst_rvalid", 32'(ldr_rvalid), 32'd0);
        checkOutput("rst_last", 32'(ldr_last), 32'd0);

        // Halted CPU: loader writes A0..A5 to 0x00..0x05 in a 4-beat and a 2-beat grant
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'd0, 8'hA0);
        checkOutput("s2_cpu_gnt", 32'(ldr_gnt), 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'd0, 8'hA0);
        checkOutput("s2_turn_gnt", 32'(ldr_gnt), 32'd0);
        checkOutput("s2_turn_wr", 32'(mem_wr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'(i), 8'hA0 + 8'(i));
            checkOutput($sformatf("s2_b%0d_gnt", i), 32'(ldr_gnt), 32'd1);
            checkOutput($sformatf("s2_b%0d_wr", i), 32'(mem_wr), 32'd1);
            checkOutput($sformatf("s2_b%0d_addr", i), 32'(mem_addr), 32'(i));
            checkOutput($sformatf("s2_b%0d_last", i), 32'(ldr_last), (i == 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'd4, 8'hA4);
        checkOutput("s2_cpu2_gnt", 32'(ldr_gnt), 32'd0);
        checkOutput("s2_cpu2_wr", 32'(mem_wr), 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'd4, 8'hA4);
        checkOutput("s2_turn2_gnt", 32'(ldr_gnt), 32'd0);
        for (int i = 4; i < 6; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'(i), 8'hA0 + 8'(i));
            checkOutput($sformatf("s2_b%0d_gnt", i), 32'(ldr_gnt), 32'd1);
            checkOutput($sformatf("s2_b%0d_wr", i), 32'(mem_wr), 32'd1);
            checkOutput($sformatf("s2_b%0d_last", i), 32'(ldr_last), 32'd0);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s2_stop_gnt", 32'(ldr_gnt), 32'd1);
        checkOutput("s2_stop_wr", 32'(mem_wr), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s2_end_gnt", 32'(ldr_gnt), 32'd0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("s2_mem%0d", i), 32'(tb_mem[i]), 32'(8'hA0 + 8'(i)));
        end

        // CPU reads every cycle; forced grant after STARVE_LIMIT cycles, CPU holds on stall
        ca = 5'h08;
        performed = 0;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(0, 0, 1, 0, ca, 0, (k < 13) ? 1'b1 : 1'b0, 0, 5'h10, 0);
            checkOutput($sformatf("s3_k%0d_stall", k), 32'(cpu_stall),
                        (k >= 8 && k <= 12) ? 32'd1 : 32'd0);
            checkOutput($sformatf("s3_k%0d_gnt", k), 32'(ldr_gnt),
                        (k >= 9 && k <= 12) ? 32'd1 : 32'd0);
            if (k == 8) checkOutput("s3_turn_rd", 32'(mem_rd), 32'd0);
            if (k >= 9 && k <= 12) begin
                checkOutput($sformatf("s3_k%0d_laddr", k), 32'(mem_addr), 32'h10);
                checkOutput($sformatf("s3_k%0d_last", k), 32'(ldr_last),
                            (k == 12) ? 32'd1 : 32'd0);
            end
            if (k == 9) checkOutput("s3_rvalid_early", 32'(ldr_rvalid), 32'd0);
            if (k == 13) checkOutput("s3_rvalid_late", 32'(ldr_rvalid), 32'd1);
            if (!cpu_stall) begin
                checkOutput($sformatf("s3_k%0d_caddr", k), 32'(mem_addr), 32'(ca));
                if (mem_rd && mem_addr == ca) performed++;
                ca = ca + 5'd1;
            end
        end
        checkOutput("s3_cpu_accesses", 32'(performed), 32'd9);
`ifdef ARB_STATS_EN
        checkOutput("s6_stall_cnt", 32'(stat_stall_cnt), 32'd5);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // CPU idle: loader writes 0x5A to 0x1F then reads it back
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 5'h1F, 8'h5A);
        checkOutput("s4_cpu_gnt", 32'(ldr_gnt), 32'd0);
        checkOutput("s4_cpu_rd", 32'(mem_rd), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 5'h1F, 8'h5A);
        checkOutput("s4_turn_gnt", 32'(ldr_gnt), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 5'h1F, 8'h5A);
        checkOutput("s4_wr", 32'(mem_wr), 32'd1);
        checkOutput("s4_wdata", 32'(mem_wdata), 32'h5A);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 5'h1F, 0);
        checkOutput("s4_rd", 32'(mem_rd), 32'd1);
        checkOutput("s4_raddr", 32'(mem_addr), 32'h1F);
        checkOutput("s4_rvalid_beat", 32'(ldr_rvalid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s4_rvalid", 32'(ldr_rvalid), 32'd1);
        checkOutput("s4_rdata", 32'(ldr_rdata), 32'h5A);
        checkOutput("s4_stop_rd", 32'(mem_rd), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s4_rvalid_drop", 32'(ldr_rvalid), 32'd0);
        checkOutput("s4_end_gnt", 32'(ldr_gnt), 32'd0);

        // Reset during beat 2 of a read burst
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 5'd2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 5'd2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 5'd2, 0);
        checkOutput("s5_b1_gnt", 32'(ldr_gnt), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 5'd3, 0);
        checkOutput("s5_b2_gnt", 32'(ldr_gnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 5'd4, 0);
        checkOutput("s5_post_gnt", 32'(ldr_gnt), 32'd0);
        checkOutput("s5_post_rvalid", 32'(ldr_rvalid), 32'd0);
        checkOutput("s5_post_stall", 32'(cpu_stall), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
